encode_emulator: RTL and testbench
==================================

# encode_emulator

Synthetic encoder source generating the coarse W (rotary) / X (linear) encode update stream consumed by the encode interpolation stage. It drives `x_zero_flag`, `encode_update`, `encode_w` and `encode_x` at a programmable update interval, with modular W wrap at the encode mask maximum and a bounded X ramp. It replaces the motion-controller encoder receiver when the board runs bench/self-test scans.

## Interface
- `TCQ`, 0.1, simulation clock-to-q delay on all register assignments.
- `ENCODE_MASK_WID`, 32, W valid width; W range 0..W_MAX-1, W_MAX = 2^ENCODE_MASK_WID-1.
- `ENCODE_WID`, 32, encode output width (≥ ENCODE_MASK_WID).
- `INTERVAL_WID`, 16, width of the update interval counter.

Ports:
- `clk_i` in 1 system clock (100 MHz).
- `rst_i` in 1 reset. Synchronous, active-high.
- `emu_start_i` in 1 one-cycle start pulse. Accepted only in IDLE.
- `emu_stop_i` in 1 one-cycle abort pulse.
- `cfg_interval_i` in INTERVAL_WID clocks between updates. Values <2 are treated as 2.
- `cfg_w_step_i` in ENCODE_WID W increment per update.
- `cfg_x_start_i` in ENCODE_WID (signed) X value after zero.
- `cfg_x_step_i` in ENCODE_WID (signed) X increment per update.
- `cfg_x_end_i` in ENCODE_WID (signed) X terminal value.
- `x_zero_flag_o` out 1 one-cycle pulse at scan start.
- `encode_update_o` out 1 one-cycle update strobe.
- `encode_w_o` out ENCODE_WID current W. Upper bits above ENCODE_MASK_WID are zero.
- `encode_x_o` out ENCODE_WID (signed) current X.
- `emu_busy_o` out 1 high in ZERO/RUN.
- `emu_done_o` out 1 one-cycle pulse on normal or aborted completion.
- `update_cnt_o` out 32 updates issued since last start.
- `wrap_cnt_o` out 16 W wrap-arounds since last start. Saturates at 0xFFFF.

## Operation
- FSM states: IDLE, ZERO, RUN, DONE.
- **IDLE**
  - On `emu_start_i` with no `emu_stop_i` in the same cycle: latch all `cfg_*` into shadow registers, then go to ZERO.
  - Interval clamp applied at latch.
  - `cfg_w_step_i` saturated to W_MAX-1 at latch.
- **ZERO** (exactly 1 cycle)
  - `x_zero_flag_o`=1, `encode_w_o`←0, `encode_x_o`←x_start.
  - Clear counters (`update_cnt_o`, `wrap_cnt_o`) and the interval counter; go to RUN.
- **RUN**
  - Interval counter counts 0..interval-1.
  - At terminal count:
    - `encode_update_o`=1, `update_cnt_o`+1.
    - W/X outputs advance in the same cycle as the strobe, so the strobe qualifies the new values.
  - W next = W+step (ENCODE_MASK_WID+1-bit sum); if sum ≥ W_MAX then sum−W_MAX and `wrap_cnt_o`+1.
  - X next = X+x_step, computed 1 bit wider.
    - If x_step>0 and next ≥ x_end, or x_step<0 and next ≤ x_end: clamp to x_end, this update is final, go to DONE.
    - If x_step=0: never terminates; runs until stop.
- **DONE** (1 cycle): `emu_done_o`=1, go to IDLE.
- `emu_stop_i` in ZERO or RUN:
  - Next state DONE; no further `encode_update_o`.
  - A stop coinciding with a terminal count suppresses that update.
- `emu_start_i` outside IDLE is ignored.
- Outputs hold their last values in IDLE/DONE. Config changes outside IDLE have no effect.

## Timing
- Reset values (all outputs, one cycle after `rst_i`): flags 0, `encode_w_o`=0, `encode_x_o`=0, counters 0, state IDLE.
- `rst_i` mid-run aborts immediately; no `emu_done_o` pulse.
- All outputs are registered.
- Start sequence: start sampled at cycle T → `x_zero_flag_o` and zero values at T+1.
- Update timing:
  - First `encode_update_o` at T+1+interval.
  - Subsequent updates exactly every interval cycles.
- Final update at cycle U → `emu_done_o` at U+1, `emu_busy_o` low at U+1.
- Stop sampled at cycle S → `emu_done_o` at S+1.
- Back-to-back: a start in the cycle after DONE is accepted.

## Test plan
- **Basic ramp:** interval=4000, w_step=100, x_start=0, x_step=10, x_end=50.
  - `x_zero_flag_o` at T+1.
  - Five updates at T+1+4000k (k=1..5) with X=10..50 and W=100..500.
  - `emu_done_o` one cycle after the 5th update; `update_cnt_o`=5.
- **W wrap:** ENCODE_MASK_WID=8 (W_MAX=255), w_step=100, x_step=0.
  - W sequence 100, 200, 45, 145, 245, 90.
  - `wrap_cnt_o` increments on the 3rd and 6th updates.
- **Negative X with overshoot clamp:** x_start=100, x_step=−30, x_end=0.
  - X sequence 70, 40, 10, 0 (clamped), then done.
  - Check the signed outputs are correct.
- **Stop coinciding with the 3rd terminal count:**
  - Only 2 updates issued; `emu_done_o` next cycle.
  - Outputs hold the 2nd update's values.
- **Interval clamp and start/stop collision:**
  - interval=0 gives updates every 2 cycles.
  - Start+stop in the same IDLE cycle: no `x_zero_flag_o`, stays IDLE.
  - Start while busy is ignored.
- **Reset mid-RUN:**
  - All outputs at reset values next cycle; no `emu_done_o`.
  - A fresh start then reproduces the basic ramp scenario exactly.

Source files
------------

// File: rtl/encode_emulator.sv
// Synthetic W/X encoder source: programmable-interval update strobe, modular W wrap, clamped X ramp.
// All outputs registered; strobe qualifies new W/X in the same cycle. No backpressure: the consumer must take every update.
module encode_emulator #(
  parameter int ENCODE_MASK_WID = 32,
  parameter int ENCODE_WID      = 32,
  parameter int INTERVAL_WID    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    emu_start_i,
  input  logic                    emu_stop_i,
  input  logic [INTERVAL_WID-1:0] cfg_interval_i,
  input  logic [ENCODE_WID-1:0]   cfg_w_step_i,
  input  logic [ENCODE_WID-1:0]   cfg_x_start_i,
  input  logic [ENCODE_WID-1:0]   cfg_x_step_i,
  input  logic [ENCODE_WID-1:0]   cfg_x_end_i,
  output logic                    x_zero_flag_o,
  output logic                    encode_update_o,
  output logic [ENCODE_WID-1:0]   encode_w_o,
  output logic [ENCODE_WID-1:0]   encode_x_o,
  output logic                    emu_busy_o,
  output logic                    emu_done_o,
  output logic [31:0]             update_cnt_o,
  output logic [15:0]             wrap_cnt_o
);

  localparam int MW = ENCODE_MASK_WID;
  localparam int EW = ENCODE_WID;
  localparam int IW = INTERVAL_WID;
  localparam logic [MW:0] LP_W_MAX    = {1'b0, {MW{1'b1}}};
  localparam logic [EW:0] LP_STEP_MAX = {{(EW-MW+1){1'b0}}, {(MW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_ZERO, S_RUN, S_DONE} state_t;

  state_t          r_state, w_next_state;
  logic [IW-1:0]   r_interval, r_cnt;
  logic [MW-1:0]   r_w_step, r_w;
  logic [EW-1:0]   r_x_step, r_x_end, r_x;
  logic            r_final, r_zero, r_upd, r_done, r_busy;
  logic [31:0]     r_update_cnt;
  logic [15:0]     r_wrap_cnt;

  logic            w_latch, w_count, w_fire, w_term, w_wrap, w_x_last;
  logic [IW-1:0]   w_interval_clamped;
  logic [MW-1:0]   w_w_step_sat, w_w_next;
  logic [MW:0]     w_w_sum;
  logic signed [EW:0] w_x_sum, w_x_end_ext;
  logic [EW-1:0]   w_x_next;

  assign w_interval_clamped = (cfg_interval_i < IW'(2)) ? IW'(2) : cfg_interval_i;
  assign w_w_step_sat = ({1'b0, cfg_w_step_i} >= LP_STEP_MAX) ? LP_STEP_MAX[MW-1:0]
                                                              : cfg_w_step_i[MW-1:0];
  assign w_term = (r_cnt == r_interval - IW'(1));

  // W stays in 0..W_MAX-1 because the step is capped at W_MAX-1
  assign w_w_sum  = {1'b0, r_w} + {1'b0, r_w_step};
  assign w_wrap   = (w_w_sum >= LP_W_MAX);
  assign w_w_next = MW'(w_wrap ? (w_w_sum - LP_W_MAX) : w_w_sum);

  assign w_x_sum     = {r_x[EW-1], r_x} + {r_x_step[EW-1], r_x_step};
  assign w_x_end_ext = {r_x_end[EW-1], r_x_end};
  assign w_x_last = (!r_x_step[EW-1] && (r_x_step != '0) && (w_x_sum >= w_x_end_ext)) ||
                    (r_x_step[EW-1] && (w_x_sum <= w_x_end_ext));
  assign w_x_next = w_x_last ? r_x_end : w_x_sum[EW-1:0];

  // The final update leaves RUN one cycle later so done trails the last strobe by one cycle
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_count      = 1'b0;
    w_fire       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (emu_start_i && !emu_stop_i) begin
          w_next_state = S_ZERO;
          w_latch      = 1'b1;
        end
      end
      S_ZERO: begin
        w_count      = 1'b1;
        w_next_state = emu_stop_i ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (emu_stop_i || r_final) begin
          w_next_state = S_DONE;
        end else begin
          w_count = 1'b1;
          w_fire  = w_term;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_interval   <= '0;
      r_cnt        <= '0;
      r_w_step     <= '0;
      r_w          <= '0;
      r_x_step     <= '0;
      r_x_end      <= '0;
      r_x          <= '0;
      r_final      <= 1'b0;
      r_zero       <= 1'b0;
      r_upd        <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_update_cnt <= '0;
      r_wrap_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_zero  <= w_latch;
      r_upd   <= w_fire;
      r_done  <= (w_next_state == S_DONE);
      r_busy  <= (w_next_state == S_ZERO) || (w_next_state == S_RUN);
      if (w_latch) begin
        r_interval   <= w_interval_clamped;
        r_w_step     <= w_w_step_sat;
        r_x_step     <= cfg_x_step_i;
        r_x_end      <= cfg_x_end_i;
        r_x          <= cfg_x_start_i;
        r_w          <= '0;
        r_cnt        <= '0;
        r_final      <= 1'b0;
        r_update_cnt <= '0;
        r_wrap_cnt   <= '0;
      end else if (w_count) begin
        r_cnt <= w_term ? '0 : r_cnt + IW'(1);
      end
      if (w_fire) begin
        r_w          <= w_w_next;
        r_x          <= w_x_next;
        r_final      <= w_x_last;
        r_update_cnt <= r_update_cnt + 32'd1;
        if (w_wrap && (r_wrap_cnt != 16'hFFFF)) r_wrap_cnt <= r_wrap_cnt + 16'd1;
      end
    end
  end

  assign x_zero_flag_o   = r_zero;
  assign encode_update_o = r_upd;
  assign encode_w_o      = EW'(r_w);
  assign encode_x_o      = r_x;
  assign emu_busy_o      = r_busy;
  assign emu_done_o      = r_done;
  assign update_cnt_o    = r_update_cnt;
  assign wrap_cnt_o      = r_wrap_cnt;

endmodule

// File: tb/tb_encode_emulator.sv
// Bench for encode_emulator: table of scans plus hand-written stop/collision/wrap/reset sequences,
// with every update strobe checked against a queue filled by a 64-bit reference model.
module tb_encode_emulator;

  logic        clk_i = 1'b0;
  logic        rst_i, emu_start_i, emu_stop_i;
  logic [15:0] cfg_interval_i;
  logic [31:0] cfg_w_step_i, cfg_x_start_i, cfg_x_step_i, cfg_x_end_i;

  logic        x_zero_flag_o, encode_update_o, emu_busy_o, emu_done_o;
  logic [31:0] encode_w_o, encode_x_o, update_cnt_o;
  logic [15:0] wrap_cnt_o;

  logic        zero_8, upd_8, busy_8, done_8;
  logic [31:0] w_8, x_8, ucnt_8;
  logic [15:0] wrap_8;

  encode_emulator dut (
    .clk_i(clk_i), .rst_i(rst_i), .emu_start_i(emu_start_i), .emu_stop_i(emu_stop_i),
    .cfg_interval_i(cfg_interval_i), .cfg_w_step_i(cfg_w_step_i), .cfg_x_start_i(cfg_x_start_i),
    .cfg_x_step_i(cfg_x_step_i), .cfg_x_end_i(cfg_x_end_i),
    .x_zero_flag_o(x_zero_flag_o), .encode_update_o(encode_update_o), .encode_w_o(encode_w_o),
    .encode_x_o(encode_x_o), .emu_busy_o(emu_busy_o), .emu_done_o(emu_done_o),
    .update_cnt_o(update_cnt_o), .wrap_cnt_o(wrap_cnt_o)
  );

  encode_emulator #(.ENCODE_MASK_WID(8)) dut8 (
    .clk_i(clk_i), .rst_i(rst_i), .emu_start_i(emu_start_i), .emu_stop_i(emu_stop_i),
    .cfg_interval_i(cfg_interval_i), .cfg_w_step_i(cfg_w_step_i), .cfg_x_start_i(cfg_x_start_i),
    .cfg_x_step_i(cfg_x_step_i), .cfg_x_end_i(cfg_x_end_i),
    .x_zero_flag_o(zero_8), .encode_update_o(upd_8), .encode_w_o(w_8),
    .encode_x_o(x_8), .emu_busy_o(busy_8), .emu_done_o(done_8),
    .update_cnt_o(ucnt_8), .wrap_cnt_o(wrap_8)
  );

  always #5 clk_i = ~clk_i;

  longint cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] w;
    logic [31:0] x;
    int          ucnt;
    int          wcnt;
    longint      cyc;
  } exp_t;

  typedef struct {
    int          ivl;
    logic [31:0] wstep;
    logic [31:0] xs;
    logic [31:0] xstep;
    logic [31:0] xend;
    int          n;
    logic [31:0] last_x;
  } vec_t;

  exp_t q[$];
  exp_t q8[$];
  bit   chk8 = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin : mon
    exp_t e;
    if (encode_update_o) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_update: strobe at cycle %0d, none expected", cyc);
      end else begin
        e = q.pop_front();
        chk("upd_w", encode_w_o, e.w);
        chk("upd_x", encode_x_o, e.x);
        chk("upd_cnt", update_cnt_o, e.ucnt);
        chk("upd_wrap", wrap_cnt_o, e.wcnt);
        chk("upd_cycle", cyc, e.cyc);
      end
    end
    if (chk8 && upd_8) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_update8: strobe at cycle %0d, none expected", cyc);
      end else begin
        e = q8.pop_front();
        chk("upd8_w", w_8, e.w);
        chk("upd8_wrap", wrap_8, e.wcnt);
        chk("upd8_cycle", cyc, e.cyc);
      end
    end
  end

  // Reference model: 64-bit arithmetic, pushes every expected strobe with its due cycle
  task automatic push_model(input vec_t v, input int maxn, input int mw, input bit to8,
                            input longint t0, output longint last_cyc);
    longint wmax, w, st, x, sx, xe;
    int     iv, wraps;
    bit     fin;
    exp_t   e;
    wmax = (longint'(1) << mw) - 1;
    st   = longint'(v.wstep);
    if (st > wmax - 1) st = wmax - 1;
    x  = longint'($signed(v.xs));
    sx = longint'($signed(v.xstep));
    xe = longint'($signed(v.xend));
    iv = (v.ivl < 2) ? 2 : v.ivl;
    w = 0; wraps = 0; fin = 1'b0; last_cyc = t0 + 1;
    for (int k = 1; k <= maxn && !fin; k++) begin
      w = w + st;
      if (w >= wmax) begin
        w = w - wmax;
        if (wraps < 65535) wraps++;
      end
      x = x + sx;
      if ((sx > 0 && x >= xe) || (sx < 0 && x <= xe)) begin
        x = xe;
        fin = 1'b1;
      end
      e.w = w[31:0]; e.x = x[31:0]; e.ucnt = k; e.wcnt = wraps;
      e.cyc = t0 + 1 + longint'(iv) * k;
      if (to8) q8.push_back(e); else q.push_back(e);
      last_cyc = e.cyc;
    end
  endtask

  // Advances one cycle, pulses start with the given config, checks the zero cycle
  task automatic do_start(input vec_t v, output longint t0);
    @(negedge clk_i);
    cfg_interval_i = 16'(v.ivl);
    cfg_w_step_i = v.wstep; cfg_x_start_i = v.xs; cfg_x_step_i = v.xstep; cfg_x_end_i = v.xend;
    emu_start_i = 1'b1;
    t0 = cyc;
    @(negedge clk_i);
    emu_start_i = 1'b0;
    chk("zero_flag", x_zero_flag_o, 1);
    chk("zero_w", encode_w_o, 0);
    chk("zero_x", encode_x_o, v.xs);
    chk("zero_busy", emu_busy_o, 1);
    chk("zero_ucnt", update_cnt_o, 0);
  endtask

  task automatic wait_done(input string nm, input int n, input logic [31:0] lx, input longint exp_cyc);
    while (!emu_done_o && cyc < exp_cyc + 20) @(negedge clk_i);
    if (!emu_done_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done_timeout: no emu_done_o by cycle %0d, required at %0d", nm, cyc, exp_cyc);
    end else begin
      chk({nm, "_done_cycle"}, cyc, exp_cyc);
      chk({nm, "_ucnt"}, update_cnt_o, n);
      chk({nm, "_final_x"}, encode_x_o, lx);
      chk({nm, "_busy"}, emu_busy_o, 0);
      chk({nm, "_pending"}, q.size(), 0);
    end
  endtask

  initial begin
    vec_t   vt[5];
    vec_t   v;
    longint t0, lc, lc8;

    vt = '{
      '{4000, 32'd100,        32'd0,    32'd10,   32'd50,   5, 32'd50},
      '{6,    32'd7,          32'd100,  -32'sd30, 32'd0,    4, 32'd0},
      '{0,    32'd3,          32'd5,    32'd1,    32'd8,    3, 32'd8},
      '{1,    32'd9,          -32'sd20, -32'sd7,  -32'sd40, 3, -32'sd40},
      '{3,    32'hFFFF_FFFF,  32'd0,    32'd1,    32'd3,    3, 32'd3}
    };

    rst_i = 1'b1; emu_start_i = 1'b0; emu_stop_i = 1'b0;
    cfg_interval_i = '0; cfg_w_step_i = '0; cfg_x_start_i = '0; cfg_x_step_i = '0; cfg_x_end_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_zero", x_zero_flag_o, 0);
    chk("rst_upd", encode_update_o, 0);
    chk("rst_w", encode_w_o, 0);
    chk("rst_x", encode_x_o, 0);
    chk("rst_busy", emu_busy_o, 0);
    chk("rst_done", emu_done_o, 0);
    chk("rst_ucnt", update_cnt_o, 0);
    chk("rst_wrap", wrap_cnt_o, 0);
    rst_i = 1'b0;

    // Table scans run back-to-back: each start lands in the cycle after the previous done
    for (int i = 0; i < 5; i++) begin
      do_start(vt[i], t0);
      push_model(vt[i], 1000, 32, 1'b0, t0, lc);
      wait_done($sformatf("vec%0d", i), vt[i].n, vt[i].last_x, lc + 1);
    end

    // Start and stop together in IDLE
    @(negedge clk_i);
    emu_start_i = 1'b1; emu_stop_i = 1'b1;
    @(negedge clk_i);
    emu_start_i = 1'b0; emu_stop_i = 1'b0;
    chk("collide_zero", x_zero_flag_o, 0);
    chk("collide_busy", emu_busy_o, 0);
    @(negedge clk_i);
    chk("collide_idle", emu_busy_o, 0);

    // Stop on the 3rd terminal count
    v = '{5, 32'd7, 32'd0, 32'd1, 32'd100, 2, 32'd2};
    do_start(v, t0);
    push_model(v, 2, 32, 1'b0, t0, lc);
    while (cyc < t0 + 15) @(negedge clk_i);
    emu_stop_i = 1'b1;
    @(negedge clk_i);
    emu_stop_i = 1'b0;
    chk("stop_done", emu_done_o, 1);
    chk("stop_no_upd", encode_update_o, 0);
    chk("stop_w", encode_w_o, 14);
    chk("stop_x", encode_x_o, 2);
    chk("stop_ucnt", update_cnt_o, 2);
    chk("stop_busy", emu_busy_o, 0);
    @(negedge clk_i);
    chk("stop_done_pulse", emu_done_o, 0);
    chk("stop_pending", q.size(), 0);

    // Start while busy (with altered config) is ignored
    v = '{4, 32'd1, 32'd0, 32'd1, 32'd3, 3, 32'd3};
    do_start(v, t0);
    push_model(v, 1000, 32, 1'b0, t0, lc);
    while (cyc < t0 + 6) @(negedge clk_i);
    cfg_x_start_i = 32'd77; cfg_x_step_i = 32'd5; cfg_interval_i = 16'd9;
    emu_start_i = 1'b1;
    @(negedge clk_i);
    emu_start_i = 1'b0;
    chk("busy_start_zero", x_zero_flag_o, 0);
    chk("busy_start_busy", emu_busy_o, 1);
    wait_done("busy_start", v.n, v.last_x, lc + 1);

    // W wrap on the 8-bit mask instance, X held (step 0) until stopped
    chk8 = 1'b1;
    v = '{3, 32'd100, -32'sd5, 32'd0, 32'd0, 6, -32'sd5};
    do_start(v, t0);
    push_model(v, 6, 32, 1'b0, t0, lc);
    push_model(v, 6, 8, 1'b1, t0, lc8);
    while (cyc < t0 + 19) @(negedge clk_i);
    emu_stop_i = 1'b1;
    @(negedge clk_i);
    emu_stop_i = 1'b0;
    chk("wrap_done", emu_done_o, 1);
    chk("wrap8_done", done_8, 1);
    chk("wrap8_w", w_8, 90);
    chk("wrap8_cnt", wrap_8, 2);
    chk("wrap8_x", x_8, v.xs);
    chk("wrap_ucnt", update_cnt_o, 6);
    chk("wrap_main_w", encode_w_o, 600);
    chk("wrap_main_cnt", wrap_cnt_o, 0);
    chk("wrap_pending", q.size(), 0);
    chk("wrap8_pending", q8.size(), 0);
    chk8 = 1'b0;

    // Reset in the middle of the basic ramp, then rerun it
    do_start(vt[0], t0);
    push_model(vt[0], 1000, 32, 1'b0, t0, lc);
    while (cyc < t0 + 8005) @(negedge clk_i);
    chk("pre_rst_ucnt", update_cnt_o, 2);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    q.delete();
    chk("mid_rst_w", encode_w_o, 0);
    chk("mid_rst_x", encode_x_o, 0);
    chk("mid_rst_busy", emu_busy_o, 0);
    chk("mid_rst_done", emu_done_o, 0);
    chk("mid_rst_ucnt", update_cnt_o, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("post_rst_no_done", emu_done_o, 0);
    end
    do_start(vt[0], t0);
    push_model(vt[0], 1000, 32, 1'b0, t0, lc);
    wait_done("rerun", vt[0].n, vt[0].last_x, lc + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
